// File: rtl/lms_coeff_update.sv
// Serial LMS coefficient-update engine: one tap per cycle, published atomically through a shadow bank.
// Optional leaky update is enabled by defining LMS_LEAKAGE_EN (leak amount set by LEAK_SHIFT).
module lms_coeff_update #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int TAPS       = 4,
    parameter int LEAK_SHIFT = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [WIDTH-1:0]             i_din,
    input  logic [WIDTH-1:0]             i_err,
    input  logic [WIDTH-1:0]             i_mu,
    input  logic                         i_valid,
    input  logic                         i_clear,
    output logic                         o_ready,
    output logic [TAPS-1:0][WIDTH-1:0]   o_coeffs,
    output logic                         o_coeff_valid,
    output logic                         o_miss,
    output logic                         o_ovr
);
    localparam int PW = 2 * WIDTH;
    localparam int KW = $clog2(TAPS);
    localparam logic signed [PW-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    if (TAPS < 2 || LEAK_SHIFT < 0 || LEAK_SHIFT >= WIDTH) begin : g_param_check
        $error("lms_coeff_update: TAPS must be >= 2 and LEAK_SHIFT within [0, WIDTH)");
    end

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    state_t                       state, state_nx;
    logic [TAPS-1:0][WIDTH-1:0]   xdl, wk, wk_next, shadow;
    logic [WIDTH-1:0]             mue, new_wk, mue_sat;
    logic [KW-1:0]                k;
    logic                         accept, busy_hit, last_tap, mue_clamp, tap_clamp;
    logic signed [PW-1:0]         mu_x, err_x, mue_full, mue_x, xk_x, term_full, term_x, wk_x, sum_x;
`ifdef LMS_LEAKAGE_EN
    logic signed [PW-1:0]         leak_x;
`endif

    function automatic logic signed [PW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    function automatic logic clamps(input logic signed [PW-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        o_ready  = (state == S_IDLE);
        last_tap = (k == KW'(TAPS - 1));
        accept   = (state == S_IDLE) && i_valid && !i_clear;
        busy_hit = (state != S_IDLE) && i_valid && !i_clear;
        if (i_clear) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (i_valid) state_nx = S_UPDATE;
                S_UPDATE: if (last_tap) state_nx = S_DONE;
                S_DONE:   state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    // Full-precision products; truncation is the arithmetic right shift.
    always_comb begin
        mu_x      = sext(i_mu);
        err_x     = sext(i_err);
        mue_full  = (mu_x * err_x) >>> FRAC;
        mue_sat   = sat(mue_full);
        mue_clamp = clamps(mue_full);
        mue_x     = sext(mue);
        xk_x      = sext(xdl[k]);
        wk_x      = sext(wk[k]);
        term_full = (mue_x * xk_x) >>> FRAC;
        term_x    = sext(sat(term_full));
`ifdef LMS_LEAKAGE_EN
        leak_x    = wk_x >>> LEAK_SHIFT;
        sum_x     = wk_x - leak_x + term_x;
`else
        sum_x     = wk_x + term_x;
`endif
        new_wk    = sat(sum_x);
        tap_clamp = clamps(term_full) || clamps(sum_x);
        wk_next    = wk;
        wk_next[k] = new_wk;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            xdl           <= '0;
            wk            <= '0;
            shadow        <= '0;
            mue           <= '0;
            k             <= '0;
            o_coeff_valid <= 1'b0;
            o_miss        <= 1'b0;
            o_ovr         <= 1'b0;
        end else if (i_clear) begin
            xdl           <= '0;
            wk            <= '0;
            shadow        <= '0;
            mue           <= '0;
            k             <= '0;
            o_coeff_valid <= 1'b0;
            o_miss        <= 1'b0;
            o_ovr         <= 1'b0;
        end else begin
            o_coeff_valid <= 1'b0;
            o_miss        <= busy_hit;
            if (accept) begin
                xdl <= {xdl[TAPS-2:0], i_din};
                mue <= mue_sat;
                k   <= '0;
                if (mue_clamp) o_ovr <= 1'b1;
            end
            if (state == S_UPDATE) begin
                wk <= wk_next;
                k  <= k + 1'b1;
                if (tap_clamp) o_ovr <= 1'b1;
                // Publish on the edge entering DONE, including the tap finished this cycle.
                if (last_tap) begin
                    shadow        <= wk_next;
                    o_coeff_valid <= 1'b1;
                end
            end
        end
    end

    assign o_coeffs = shadow;

endmodule

// File: tb/tb_lms_coeff_update.sv
// Directed and randomized bench for lms_coeff_update against an arithmetic reference model.
module tb_lms_coeff_update;
    localparam int WIDTH = 16;
    localparam int FRAC  = 14;
    localparam int TAPS  = 4;
    localparam int LEAK  = 4;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic                          i_clk = 1'b0;
    logic                          i_rst = 1'b1;
    logic [WIDTH-1:0]              i_din = '0, i_err = '0, i_mu = '0;
    logic                          i_valid = 1'b0, i_clear = 1'b0;
    logic                          o_ready, o_coeff_valid, o_miss, o_ovr;
    logic [TAPS-1:0][WIDTH-1:0]    o_coeffs;

    int checks = 0;
    int errors = 0;

    longint mx[TAPS];
    longint mw[TAPS];
    bit     m_ovr;

    lms_coeff_update #(.WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS), .LEAK_SHIFT(LEAK)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_din(i_din), .i_err(i_err), .i_mu(i_mu),
        .i_valid(i_valid), .i_clear(i_clear), .o_ready(o_ready), .o_coeffs(o_coeffs),
        .o_coeff_valid(o_coeff_valid), .o_miss(o_miss), .o_ovr(o_ovr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat_m(input longint v);
        if (v > MAXV) begin m_ovr = 1'b1; return MAXV; end
        if (v < MINV) begin m_ovr = 1'b1; return MINV; end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mw[k] = 0; end
        m_ovr = 1'b0;
    endtask

    task automatic model_accept(input longint din, input longint err, input longint mu);
        longint mue, t, s;
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = din;
        mue = sat_m((mu * err) >>> FRAC);
        for (int k = 0; k < TAPS; k++) begin
            t = sat_m((mue * mx[k]) >>> FRAC);
`ifdef LMS_LEAKAGE_EN
            s = mw[k] - (mw[k] >>> LEAK) + t;
`else
            s = mw[k] + t;
`endif
            mw[k] = sat_m(s);
        end
    endtask

    function automatic logic [63:0] exp_coeffs();
        logic [63:0] r;
        longint      tmp;
        r = '0;
        for (int k = 0; k < TAPS; k++) begin
            tmp = mw[k];
            r[k*WIDTH +: WIDTH] = tmp[WIDTH-1:0];
        end
        return r;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) check({tag, "_ready_timeout"}, 64'(o_ready), 64'd1);
    endtask

    // One accept; busy_at > 0 raises a second i_valid in that cycle of the update.
    task automatic accept_run(input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] err,
                              input logic [WIDTH-1:0] mu, input int busy_at, input string tag);
        logic [63:0] old_exp;
        int cv_cyc, cv_cnt, miss_cnt, miss_cyc, rdy_bad;
        cv_cyc = 0; cv_cnt = 0; miss_cnt = 0; miss_cyc = 0; rdy_bad = 0;
        wait_ready(tag);
        old_exp = exp_coeffs();
        i_din = din; i_err = err; i_mu = mu; i_valid = 1'b1;
        @(posedge i_clk);
        model_accept(longint'($signed(din)), longint'($signed(err)), longint'($signed(mu)));
        @(negedge i_clk);
        i_valid = 1'b0;
        for (int c = 1; c <= TAPS + 2; c++) begin
            if (c > 1) @(negedge i_clk);
            if (o_coeff_valid) begin cv_cnt++; if (cv_cyc == 0) cv_cyc = c; end
            if (o_miss) begin miss_cnt++; miss_cyc = c; end
            if (c <= TAPS + 1 && o_ready) rdy_bad++;
            if (c == TAPS) check({tag, "_coeffs_before_done"}, o_coeffs, old_exp);
            if (c == TAPS + 1) begin
                check({tag, "_coeffs"}, o_coeffs, exp_coeffs());
                check({tag, "_ovr"}, 64'(o_ovr), 64'(m_ovr));
            end
            if (c == TAPS + 2) check({tag, "_ready_after"}, 64'(o_ready), 64'd1);
            if (busy_at > 0 && c == busy_at) begin
                i_valid = 1'b1;
                i_din   = WIDTH'($urandom_range(0, 65535));
            end else if (busy_at > 0 && c == busy_at + 1) begin
                i_valid = 1'b0;
            end
        end
        check({tag, "_cv_cycle"}, 64'(cv_cyc), 64'(TAPS + 1));
        check({tag, "_cv_count"}, 64'(cv_cnt), 64'd1);
        check({tag, "_busy_not_ready"}, 64'(rdy_bad), 64'd0);
        check({tag, "_miss_count"}, 64'(miss_cnt), (busy_at > 0) ? 64'd1 : 64'd0);
        if (busy_at > 0) check({tag, "_miss_cycle"}, 64'(miss_cyc), 64'(busy_at + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        check({tag, "_coeffs"}, o_coeffs, 64'd0);
        check({tag, "_cv"}, 64'(o_coeff_valid), 64'd0);
        check({tag, "_miss"}, 64'(o_miss), 64'd0);
        check({tag, "_ovr"}, 64'(o_ovr), 64'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge i_clk);
        check_reset_outputs("rst_held");
        i_rst = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("rst_released");

        accept_run(16'd8192, 16'd8192, 16'd8192, 0, "basic");
        check("basic_const", o_coeffs, 64'h0000_0000_0000_0800);
        check("basic_ovr_const", 64'(o_ovr), 64'd0);

        accept_run(16'd0, 16'd8192, 16'd8192, 0, "shift");
        check("shift_const", o_coeffs, 64'h0000_0000_0800_0800);

        accept_run(16'h8000, 16'h8000, 16'd16384, 0, "sat");
        check("sat_tap0_const", 64'(o_coeffs[0]), 64'h7fff);
        check("sat_ovr_const", 64'(o_ovr), 64'd1);
        accept_run(16'h8000, 16'h8000, 16'd16384, 0, "sat_repeat");
        check("sat_repeat_tap0", 64'(o_coeffs[0]), 64'h7fff);
        check("sat_repeat_ovr", 64'(o_ovr), 64'd1);

        accept_run(16'd4096, 16'hf000, 16'd8192, 2, "busy_drop");

        wait_ready("clear");
        i_clear = 1'b1; i_valid = 1'b1; i_din = 16'h1234; i_err = 16'd8192; i_mu = 16'd8192;
        @(posedge i_clk);
        model_reset();
        @(negedge i_clk);
        i_clear = 1'b0; i_valid = 1'b0;
        check("clear_coeffs", o_coeffs, 64'd0);
        check("clear_ovr", 64'(o_ovr), 64'd0);
        check("clear_ready", 64'(o_ready), 64'd1);
        check("clear_cv", 64'(o_coeff_valid), 64'd0);
        check("clear_miss", 64'(o_miss), 64'd0);
        @(negedge i_clk);
        check("clear_cv_late", 64'(o_coeff_valid), 64'd0);
        check("clear_no_accept", 64'(o_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            accept_run(WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 65535)),
                       WIDTH'($urandom_range(0, 65535)), 0, "rand");
        end

        wait_ready("rst_mid");
        i_din = 16'd8192; i_err = 16'd8192; i_mu = 16'd8192; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        accept_run(16'd8192, 16'd8192, 16'd8192, 0, "post_rst");
        check("post_rst_const", o_coeffs, 64'h0000_0000_0000_0800);

        accept_run(16'd0, 16'd0, 16'd8192, 0, "zero_err");
`ifdef LMS_LEAKAGE_EN
        check("leak_const", o_coeffs, 64'h0000_0000_0000_0780);
`else
        check("no_leak_const", o_coeffs, 64'h0000_0000_0000_0800);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lms_coeff_update.md
# lms_coeff_update

Serial LMS coefficient-update engine that produces the coefficient vector consumed by the `direct_fir` stage of the adaptive filter. For each accepted input sample it updates every coefficient in fixed-point arithmetic, one tap per cycle. The update rule is w[k] += mu·e·x[k]. The new vector is published atomically through a shadow bank, so the downstream FIR never sees a partially updated set.

## Interface
- `WIDTH`, 16: sample, error, step and coefficient word width (two's complement)
- `FRAC`, 14: fractional bits of every fixed-point word
- `TAPS`, 4: number of coefficients; ≥2
- `LEAK_SHIFT`, 8: leakage right-shift amount; used only with `LMS_LEAKAGE_EN`

Ports:
- `i_clk` in 1: single clock; all logic rising-edge
- `i_rst` in 1: asynchronous, active-high reset
- `i_din` in WIDTH: input sample x[n], the same stream fed to the FIR
- `i_err` in WIDTH: error sample e[n]
- `i_mu` in WIDTH: step size, sampled on accept
- `i_valid` in 1: sample/error pair present
- `i_clear` in 1: synchronous clear
- `o_ready` out 1: engine idle; `i_valid` accepted only when high
- `o_coeffs` out [TAPS-1:0][WIDTH-1:0]: published coefficients, packed, tap 0 at index 0
- `o_coeff_valid` out 1: one-cycle pulse when `o_coeffs` changes
- `o_miss` out 1: one-cycle pulse when `i_valid` arrives while not ready
- `o_ovr` out 1: sticky saturation flag

## Operation
- Three states: IDLE, UPDATE, DONE. Reset state is IDLE.
- IDLE, when `i_valid` is high: the engine accepts the sample.
  - The delay line shifts: x[0]←`i_din`, x[k]←x[k-1].
  - `mue` ← sat(trunc(`i_mu`·`i_err` >>> FRAC)).
  - Tap index k←0; the state moves to UPDATE.
- UPDATE: one tap per cycle.
  - Working coefficient update: wk[k] ← sat(wk[k] + sat(trunc(mue·x[k] >>> FRAC))).
  - k increments each cycle; after k=TAPS-1 the state moves to DONE.
- DONE: lasts one cycle and then returns to IDLE.
  - The shadow bank equals the working bank.
  - `o_coeffs` shows the shadow bank.
- Arithmetic rules:
  - Products are full 2·WIDTH precision.
  - Shifts are arithmetic (truncation toward −∞).
  - sat clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Any clamp event, at either the mue stage or a tap stage, sets `o_ovr`.
- `o_ovr` clears only on reset or `i_clear`.
- `i_valid` while in UPDATE or DONE:
  - The sample is dropped and `o_miss` pulses on the next cycle.
  - No state change results.
- `i_clear`, in any state:
  - Zeroes the delay line, working bank, shadow bank and `o_ovr`.
  - Forces IDLE.
  - No `o_coeff_valid` pulse.
  - It has priority over a simultaneous `i_valid`, which is neither accepted nor flagged as a miss.
- Reset mid-update: the update aborts and every register returns to its reset value.

## Timing
- Reset values:
  - `o_ready`=1.
  - `o_coeffs`, `o_coeff_valid`, `o_miss` and `o_ovr` are all 0.
  - The delay line and working bank are 0.
- Cycle 0 = the accept edge (`i_valid` & `o_ready`).
- Cycle sequence after accept:
  - Cycles 1..TAPS: UPDATE; `o_ready`=0.
  - Cycle TAPS+1: DONE. `o_coeffs` holds the new values and `o_coeff_valid`=1.
  - Cycle TAPS+2: IDLE; `o_ready`=1.
- Throughput is one sample per TAPS+2 cycles.
- `o_coeffs` is registered and changes only on the edge entering DONE, or on clear/reset.

## Configuration
- `LMS_LEAKAGE_EN` defined: leaky LMS.
  - wk[k] ← sat(wk[k] − (wk[k] >>> LEAK_SHIFT) + sat(trunc(mue·x[k] >>> FRAC))).
  - The leak term is applied every UPDATE cycle, even when mue=0.
- `LMS_LEAKAGE_EN` undefined: the plain LMS update above; `LEAK_SHIFT` is ignored.

## Test plan
All tests use WIDTH=16, FRAC=14, TAPS=4 and run after reset.
- Basic update: `i_mu`=8192, `i_err`=8192, `i_din`=8192, then a single accept.
  - `o_coeff_valid` pulses at cycle 5.
  - `o_coeffs` = {0,0,0,2048}.
  - `o_ready` is high again at cycle 6 and `o_ovr`=0.
- Delay-line shift: a second accept with `i_din`=0 and the same mu and err.
  - `o_coeffs` = {0,0,2048,2048}.
- Saturation: `i_mu`=16384, `i_err`=−32768, `i_din`=−32768.
  - Tap 0 = 32767 and `o_ovr`=1.
  - A repeat accept keeps tap 0 = 32767 and `o_ovr`=1.
- Busy drop and clear:
  - `i_valid` at cycle 2 of an update: `o_miss` pulses once and coefficients equal the single-update result.
  - Later `i_clear` together with `i_valid`: `o_coeffs` = all 0, `o_ovr`=0, no `o_coeff_valid` pulse, `o_ready`=1.
- Reset mid-update: assert `i_rst` at cycle 3.
  - All outputs go immediately to their reset values.
  - The next accept behaves exactly as the basic-update test.
- With `LMS_LEAKAGE_EN` and `LEAK_SHIFT`=4: starting from tap 0 = 2048, accept with `i_err`=0.
  - Tap 0 = 1920; all other taps stay 0.
